// File: rtl/data_mem_if.sv
// CPU data-memory request/response bundle: one request per cycle from the CPU side,
// read responses tagged with data_valid and the echoed word address.
interface data_mem_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
);
  logic              enable;
  logic              wr;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              data_valid;
  logic [AWIDTH-1:0] addr_out;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, addr_out
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, addr_out
  );
endinterface

// File: rtl/data_mem_pipelined.sv
// Word-addressed single-port data memory with a fixed LATENCY-cycle read pipeline.
// Reads sample the array at the accepting edge and shift through LATENCY stages.
module data_mem_pipelined #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 16,
  parameter int LATENCY = 4
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int WORDS = 2 ** (AWIDTH - 1);

  logic [DWIDTH-1:0] mem_q [WORDS];

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [AWIDTH-2:0]  addr_q [LATENCY];
  logic [AWIDTH-2:0]  addr_d [LATENCY];
  logic [DWIDTH-1:0]  data_q [LATENCY];
  logic [DWIDTH-1:0]  data_d [LATENCY];

  logic [AWIDTH-2:0] word_s;
  logic              accept_s;
  logic              unused_addr_lsb_s;

  assign word_s            = bus.addr[AWIDTH-1:1];
  assign unused_addr_lsb_s = bus.addr[0];
  assign accept_s          = bus.enable & ~rst;

  // Array storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept_s && bus.wr) begin
      mem_q[word_s] <= bus.data_in;
    end
  end

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = bus.enable & ~bus.wr;
    addr_d[0] = word_s;
    data_d[0] = mem_q[word_s];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Reset drops both in-flight reads and the request presented alongside rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.data_valid = vld_q[LATENCY-1];
  assign bus.data_out   = vld_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
  assign bus.addr_out   = vld_q[LATENCY-1] ? {addr_q[LATENCY-1], 1'b0} : '0;
endmodule

// File: tb/tb_data_mem_pipelined.sv
// Scoreboard bench: the driver predicts each read response from a word-level memory model,
// a negedge monitor matches DUT responses against the queue in order and on time.
module tb_data_mem_pipelined;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LAT = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  data_mem_pipelined #(.DWIDTH(DW), .AWIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic          mon_en = 1'b0;
  exp_t          q [$];
  logic [DW-1:0] model [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One request per cycle; the model applies writes and predicts reads at issue time.
  task automatic issue(input logic en, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic r);
    int word;
    @(posedge clk);
    #1;
    rst         = r;
    bus.enable  = en;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    word        = int'(a[AW-1:1]);
    if (r) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end else if (en) begin
      if (w) begin
        model[word] = d;
      end else begin
        q.push_back('{addr: {a[AW-1:1], 1'b0},
                      data: model.exists(word) ? model[word] : 16'h0000,
                      due:  cyc + LAT});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.data_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("resp_cycle", cyc, e.due);
          chk("resp_addr", bus.addr_out, e.addr);
          chk("resp_data", bus.data_out, e.data);
        end
      end else begin
        chk("idle_outputs_zero", {bus.data_out, bus.addr_out}, 32'h0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          chk("missing_valid_due", cyc, e.due + 1000);
        end
      end
    end
  end

  initial begin
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = 16'h0000;
    bus.data_in = 16'h0000;

    issue(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    mon_en = 1'b1;
    idle(10);

    // Directed: write then read, latency and bubble placement.
    issue(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    idle(6);

    issue(1'b1, 1'b1, 16'h0020, 16'h0001, 1'b0);
    issue(1'b1, 1'b1, 16'h0022, 16'h0002, 1'b0);
    issue(1'b1, 1'b1, 16'h0024, 16'h0003, 1'b0);
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    issue(1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0);
    issue(1'b1, 1'b0, 16'h0024, 16'h0000, 1'b0);
    idle(6);

    // Read-before-write ordering, then odd-address aliasing.
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    issue(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    issue(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
    idle(6);

    // Reset mid-flight discards reads; a write alongside rst must not commit.
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    issue(1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0);
    issue(1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b1);
    idle(9);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    idle(6);

    // Top word via 0xFFFF write, read back through the even alias.
    issue(1'b1, 1'b1, 16'hFFFF, 16'hA5C3, 1'b0);
    issue(1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0);
    for (int i = 0; i < 32; i++)
      issue(1'b1, 1'b1, 16'(i * 2), 16'($urandom), 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 16'hFFFF : 16'hFFFE)
                                      : 16'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a,
            16'($urandom), 1'($urandom_range(0, 59) == 0));
    end

    idle(LAT + 3);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
